fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch sequencer for the instruction fetch stage. Owns the program counter and drives the instruction memory through a req/ack handshake. Presents one fetched instruction at a time to decode with valid/stall backpressure. Accepts branch/jump redirects from later stages and cancels any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_INC, 4, byte increment between sequential fetches.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
en  in  1  global fetch enable; gates only the start of new requests
stall  in  1  decode cannot accept fetch output this cycle
redirect_valid  in  1  load new PC (branch/jump/trap)
redirect_pc  in  32  target PC for redirect
imem_req  out  1  instruction memory request
imem_addr  out  32  request address; stable while imem_req high
imem_ack  in  1  memory response valid; ignored when imem_req low
imem_rdata  in  32  instruction word, valid with imem_ack
fetch_valid  out  1  fetch_inst/fetch_pc valid to decode
fetch_pc  out  32  PC of presented instruction
fetch_inst  out  32  presented instruction word
fetch_misalign  out  1  see Optional Feature (tied 0 when compiled out)

Behaviour:
- Reset (rst high at edge): state IDLE, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, fetch_valid=0, fetch_pc=0, fetch_inst=0, fetch_misalign=0. Wins over every other input, including in REQ state.
- States: IDLE, REQ, HOLD.
- IDLE: imem_req=0. If redirect_valid, pc<=redirect_pc. If en, go REQ next cycle with the updated pc.
- REQ: imem_req=1, imem_addr=pc, held unchanged until imem_ack. A request is never withdrawn before ack.
  - ack with kill=0: capture fetch_inst<=imem_rdata, fetch_pc<=pc, go HOLD.
  - ack with kill=1: discard data, clear kill, go REQ next cycle at the new pc (imem_req may drop for one cycle).
  - redirect_valid in REQ with no ack: pc<=redirect_pc, kill<=1.
  - redirect_valid in the same cycle as ack: data discarded, pc<=redirect_pc, go REQ. imem_addr switches only after the ack edge.
- HOLD: fetch_valid=1; fetch_pc and fetch_inst are stable while stall=1.
  - redirect_valid (highest priority): drop fetch_valid next cycle, pc<=redirect_pc, go REQ if en, else IDLE.
  - !stall: instruction accepted; pc<=pc+PC_INC, go REQ if en, else IDLE.
  - stall: remain in HOLD.
- Timing: ack in cycle N gives fetch_valid in cycle N+1. Best-case throughput is one instruction per 2 cycles.
- Arithmetic: 32-bit, modulo 2^32; pc 32'hFFFF_FFFC + 4 wraps to 0.
- en low while in REQ does not abort; the fetch completes into HOLD.

Optional Feature:
Macro FETCH_MISALIGN_CHECK_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 is not fetched. pc still loads, any in-flight response is killed, and the FSM enters IDLE.
  - fetch_misalign is asserted from the next cycle until the next valid redirect or rst.
  - While fetch_misalign=1, en is ignored.
- Undefined: fetch_misalign is tied 0 and the low bits are passed through unchecked.

Test Plan:
- Reset, en=1, memory acks 1 cycle after each req, stall=0 -> imem_addr sequence 0,4,8,C; fetch_valid pulses every 2nd cycle with fetch_pc matching.
- HOLD at pc=8 with stall=1 for 3 cycles -> fetch_valid, fetch_pc=8, fetch_inst stable; no imem_req; pc=C request issued the cycle after stall drops.
- Redirect to 0x100 while REQ at 0x10 is waiting (ack 3 cycles later with 0xDEADBEEF) -> data dropped, fetch_valid stays 0, next imem_addr=0x100.
- HOLD at 0x20 with redirect_valid=1 to 0x40 and stall=0 together -> no advance to 0x24; next imem_addr=0x40.
- pc=0xFFFF_FFFC accepted -> next imem_addr=0; rst asserted during an outstanding REQ -> next cycle imem_req=0, imem_addr=RESET_PC, and late acks are ignored.
- FETCH_MISALIGN_CHECK_EN defined, redirect to 0x102 -> fetch_misalign=1 next cycle, imem_req stays 0; redirect to 0x104 -> flag clears, fetch resumes at 0x104.

Source files
------------

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl - instruction fetch sequencer
//
// Owns the program counter and fetches one instruction at a time from the
// instruction memory over a req/ack handshake. The fetched word is presented
// to decode with valid/stall backpressure. Redirects (branch/jump/trap) reload
// the PC and cancel any fetch that is still in flight.
//
// Parameters:
//   RESET_PC  PC value loaded on reset
//   PC_INC    byte increment between sequential fetches
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   en                         fetch enable, gates only the start of requests
//   stall                      decode cannot take the presented instruction
//   redirect_valid/redirect_pc load a new PC and cancel in-flight work
//   imem_req/imem_addr         memory request, address held until ack
//   imem_ack/imem_rdata        memory response (ignored while imem_req low)
//   fetch_valid/pc/inst        instruction presented to decode
//   fetch_misalign             misaligned redirect flag
//
// Build option: define FETCH_MISALIGN_CHECK_EN to refuse redirects whose
// target has nonzero low bits. Such a redirect loads the PC but parks the
// sequencer in IDLE with fetch_misalign set until an aligned redirect or
// reset. Without the macro fetch_misalign is tied low and low bits pass
// through unchecked.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic        kill_r;      // outstanding response must be discarded
  logic        misalign_r;  // last redirect target was misaligned

  logic        redir_bad_s;
  logic        start_ok_s;
  logic [31:0] pc_inc_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_bad_s    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_misalign = misalign_r;
`else
  assign redir_bad_s    = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  // A redirect in the same cycle decides the flag that gates en, so an
  // aligned redirect can restart fetching immediately.
  assign start_ok_s = en && !(redirect_valid ? redir_bad_s : misalign_r);
  assign pc_inc_s   = pc_r + PC_INC;

  // Sequencer state, PC and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      kill_r      <= 1'b0;
      misalign_r  <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      fetch_valid <= 1'b0;
      fetch_pc    <= 32'h0000_0000;
      fetch_inst  <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (redirect_valid) begin
            pc_r       <= redirect_pc;
            misalign_r <= redir_bad_s;
          end
          if (start_ok_s) begin
            state_r   <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= redirect_valid ? redirect_pc : pc_r;
          end
        end

        REQ: begin
          if (imem_ack) begin
            kill_r <= 1'b0;
            if (redirect_valid) begin
              // Response dropped; the new address appears only after this edge.
              pc_r       <= redirect_pc;
              misalign_r <= redir_bad_s;
              if (redir_bad_s) begin
                state_r  <= IDLE;
                imem_req <= 1'b0;
              end else begin
                imem_addr <= redirect_pc;
              end
            end else if (kill_r) begin
              // Stale response for a cancelled address; reissue at the new PC.
              if (misalign_r) begin
                state_r  <= IDLE;
                imem_req <= 1'b0;
              end else begin
                imem_addr <= pc_r;
              end
            end else begin
              state_r     <= HOLD;
              imem_req    <= 1'b0;
              fetch_valid <= 1'b1;
              fetch_pc    <= pc_r;
              fetch_inst  <= imem_rdata;
            end
          end else if (redirect_valid) begin
            // The request cannot be withdrawn, so mark its response as dead.
            pc_r       <= redirect_pc;
            kill_r     <= 1'b1;
            misalign_r <= redir_bad_s;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            fetch_valid <= 1'b0;
            pc_r        <= redirect_pc;
            misalign_r  <= redir_bad_s;
            if (start_ok_s) begin
              state_r   <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= redirect_pc;
            end else begin
              state_r <= IDLE;
            end
          end else if (!stall) begin
            fetch_valid <= 1'b0;
            pc_r        <= pc_inc_s;
            if (start_ok_s) begin
              state_r   <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc_inc_s;
            end else begin
              state_r <= IDLE;
            end
          end
        end

        default: begin
          state_r     <= IDLE;
          imem_req    <= 1'b0;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl - scoreboard bench for fetch_ctrl
//
// The reference model is the architectural instruction stream: after reset
// the next presented instruction is RESET_PC, after an accepted instruction
// it is that PC + 4, after a redirect it is the redirect target. The driver
// pushes those expectations; a monitor pops one per new presentation and
// checks pc and instruction word (memory contents are a fixed function of
// address). A memory model answers requests with random latency and issues
// spurious acks while no request is pending.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  logic        clk = 1'b0;
  logic        rst, en, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        fetch_valid, fetch_misalign;
  logic [31:0] fetch_pc, fetch_inst;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RESET_PC), .PC_INC(PC_INC)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
    .fetch_misalign(fetch_misalign)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc = 32'h0;
  int          pres_count = 0;
  int          valid_cycles = 0;
  int          max_lat = 3;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: drives ack/rdata on the falling edge.
  initial begin
    int lat_cnt;
    lat_cnt = 0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (lat_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_fn(imem_addr);
          lat_cnt    = $urandom_range(max_lat, 0);
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
          lat_cnt--;
        end
      end else begin
        imem_ack   = ($urandom_range(3, 0) == 0);
        imem_rdata = $urandom;
      end
    end
  end

  // Monitor: samples just after each rising edge.
  initial begin
    logic        prev_valid, prev_req, e_rst, e_stall, e_redir, e_ack, same;
    logic [31:0] prev_addr;
    prev_valid = 1'b0;
    prev_req   = 1'b0;
    prev_addr  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      e_rst = rst; e_stall = stall; e_redir = redirect_valid; e_ack = imem_ack;
      if (e_rst) begin
        check("rst_req", imem_req, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", fetch_valid, 32'd0);
        check("rst_fpc", fetch_pc, 32'h0);
        check("rst_finst", fetch_inst, 32'h0);
        check("rst_misalign", fetch_misalign, 32'd0);
      end else begin
        same = prev_valid && e_stall && !e_redir;
        if (same) begin
          check("hold_valid", fetch_valid, 32'd1);
          check("hold_pc", fetch_pc, cur_pc);
          check("hold_inst", fetch_inst, mem_fn(cur_pc));
        end else if (fetch_valid) begin
          pres_count++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_fetch: got pc %h, expected no presentation at %0t", fetch_pc, $time);
          end else begin
            cur_pc = exp_q.pop_front();
            check("fetch_pc", fetch_pc, cur_pc);
            check("fetch_inst", fetch_inst, mem_fn(cur_pc));
          end
        end
        if (prev_req && !e_ack) begin
          check("req_held", imem_req, 32'd1);
          check("addr_stable", imem_addr, prev_addr);
        end
`ifndef FETCH_MISALIGN_CHECK_EN
        check("misalign_tied", fetch_misalign, 32'd0);
`endif
      end
      if (fetch_valid) valid_cycles++;
      prev_valid = fetch_valid;
      prev_req   = imem_req;
      prev_addr  = imem_addr;
    end
  end

  // Apply one cycle of inputs (called on a falling edge) and update the model.
  task automatic apply(input logic st, input logic rv, input logic [31:0] rp, input logic e);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    en             = e;
    if (rv) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      if (rp[1:0] == 2'b00) exp_q.push_back(rp);
`else
      exp_q.push_back(rp);
`endif
    end else if (fetch_valid && !st) begin
      exp_q.push_back(cur_pc + PC_INC);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Stimulus.
  initial begin
    int          v0;
    logic        rv;
    logic [31:0] rp, r;
    en = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    do_reset();

    // Zero-latency memory, no stall: one instruction every two cycles.
    max_lat = 0;
    repeat (4) apply(1'b0, 1'b0, 32'h0, 1'b1);
    v0 = valid_cycles;
    repeat (20) apply(1'b0, 1'b0, 32'h0, 1'b1);
    check("throughput", valid_cycles - v0, 32'd10);

    // Wrap-around from the top of the address space.
    max_lat = 3;
    apply(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (12) apply(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomised traffic with occasional reset during an outstanding request.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 700) == 350) begin
        for (int k = 0; k < 10 && !imem_req; k++) apply(1'b0, 1'b0, 32'h0, 1'b1);
        do_reset();
      end else begin
        rv = ($urandom_range(9, 0) == 0);
        r  = $urandom;
        case ($urandom_range(3, 0))
          0: rp = 32'hFFFF_FFF0 + {r[3:2], 2'b00};
          1: rp = 32'h0000_0100;
          default: rp = r & 32'hFFFF_FFFC;
        endcase
        apply($urandom_range(2, 0) == 0, rv, rp, $urandom_range(7, 0) != 0);
      end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    repeat (10) apply(1'b0, 1'b0, 32'h0, 1'b0);
    apply(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    check("misalign_set", fetch_misalign, 32'd1);
    check("misalign_noreq", imem_req, 32'd0);
    repeat (3) apply(1'b0, 1'b0, 32'h0, 1'b1);
    check("misalign_hold", fetch_misalign, 32'd1);
    check("misalign_en_ignored", imem_req, 32'd0);
    apply(1'b0, 1'b1, 32'h0000_0104, 1'b1);
    check("misalign_clear", fetch_misalign, 32'd0);
    check("resume_req", imem_req, 32'd1);
    check("resume_addr", imem_addr, 32'h0000_0104);
    repeat (10) apply(1'b0, 1'b0, 32'h0, 1'b1);
`endif

    tests++;
    if (pres_count < 100) begin
      fails++;
      $display("FAIL liveness: got %0d presentations, expected at least 100", pres_count);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
